chacha_block_core: RTL



---
 rtl/chacha_block_core.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/chacha_block_core.sv
// -----------------------------------------------------------------------------
// chacha_block_core
//
// Iterative ChaCha block function. A request assembles the 16-word ChaCha
// state from constants, key, block counter and nonce; one column or diagonal
// round (four quarter rounds in parallel) is then evaluated per clock. On the
// last round the initial state is added back and the 512-bit block is
// registered and offered on the output handshake.
//
// Optional feature macro: CHACHA_XOR_EN
//   defined   : data_in exists, is captured on accept, ks_out = keystream ^ data
//   undefined : no data_in port, ks_out = raw keystream
//
// Parameter:
//   ROUNDS     number of rounds, must be even and >= 2 (20 = ChaCha20)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request valid
//   in_ready   core can accept a request (state == IDLE)
//   key        256-bit key, key[32i+31:32i] -> state word 4+i
//   nonce      96-bit nonce, nonce[32j+31:32j] -> state word 13+j
//   blk_cnt    block counter -> state word 12 (used as given, no increment)
//   data_in    512-bit data to XOR (CHACHA_XOR_EN only)
//   out_valid  result valid (state == DONE)
//   out_ready  consumer accepts result
//   ks_out     result block, word i at ks_out[32i+31:32i]
//   dbg_state  current FSM state (0 IDLE, 1 ROUND, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised it is held, with its data unchanged, until
// that transfer. in_ready and out_valid are pure decodes of the registered
// state, so neither depends combinationally on the other side's signals.
// -----------------------------------------------------------------------------
module chacha_block_core #(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  blk_cnt,
`ifdef CHACHA_XOR_EN
    input  logic [511:0] data_in,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] ks_out,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(ROUNDS);
    localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   rnd_cnt_q, rnd_cnt_d;
    logic [31:0]     x_q    [16];
    logic [31:0]     x_d    [16];
    logic [31:0]     init_q [16];
    logic [31:0]     init_d [16];
    logic [511:0]    ks_q, ks_d;
`ifdef CHACHA_XOR_EN
    logic [511:0]    data_q, data_d;
`endif

    logic [31:0]     start_st [16];  // state assembled from the current inputs
    logic [31:0]     rnd_res  [16];  // x_q after one round

    // Standard ChaCha quarter round; returns {a, b, c, d}.
    function automatic logic [127:0] quarter_round(input logic [31:0] a_i,
                                                   input logic [31:0] b_i,
                                                   input logic [31:0] c_i,
                                                   input logic [31:0] d_i);
        logic [31:0] a, b, c, d;
        a = a_i;
        b = b_i;
        c = c_i;
        d = d_i;
        a = a + b;  d = d ^ a;  d = {d[15:0], d[31:16]};
        c = c + d;  b = b ^ c;  b = {b[19:0], b[31:20]};
        a = a + b;  d = d ^ a;  d = {d[23:0], d[31:24]};
        c = c + d;  b = b ^ c;  b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // Initial state: constants, key, counter, nonce.
    always_comb begin
        start_st[0] = 32'h61707865;
        start_st[1] = 32'h3320646e;
        start_st[2] = 32'h79622d32;
        start_st[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            start_st[4 + i] = key[32*i +: 32];
        end
        start_st[12] = blk_cnt;
        for (int j = 0; j < 3; j++) begin
            start_st[13 + j] = nonce[32*j +: 32];
        end
    end

    // One round. Quarter round i always has a = word i; for a diagonal round
    // the b, c and d rows are rotated by 1, 2 and 3 columns respectively.
    // The four quarter rounds touch disjoint words, so all read x_q directly.
    always_comb begin
        rnd_res = x_q;
        for (int i = 0; i < 4; i++) begin
            int ib, ic, id;
            if (!rnd_cnt_q[0]) begin
                ib = 4 + i;
                ic = 8 + i;
                id = 12 + i;
            end else begin
                ib = 4 + ((i + 1) % 4);
                ic = 8 + ((i + 2) % 4);
                id = 12 + ((i + 3) % 4);
            end
            {rnd_res[i], rnd_res[ib], rnd_res[ic], rnd_res[id]} =
                quarter_round(x_q[i], x_q[ib], x_q[ic], x_q[id]);
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        rnd_cnt_d = rnd_cnt_q;
        x_d       = x_q;
        init_d    = init_q;
        ks_d      = ks_q;
`ifdef CHACHA_XOR_EN
        data_d    = data_q;
`endif
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_ROUND;
                    x_d       = start_st;
                    init_d    = start_st;
                    rnd_cnt_d = '0;
`ifdef CHACHA_XOR_EN
                    data_d    = data_in;
`endif
                end
            end
            S_ROUND: begin
                x_d = rnd_res;
                if (rnd_cnt_q == LAST_RND) begin
                    // Final round: feed-forward add goes straight from the
                    // round result into the output register.
                    for (int i = 0; i < 16; i++) begin
                        logic [31:0] ks_word;
                        ks_word = rnd_res[i] + init_q[i];
`ifdef CHACHA_XOR_EN
                        ks_word = ks_word ^ data_q[32*i +: 32];
`endif
                        ks_d[32*i +: 32] = ks_word;
                    end
                    rnd_cnt_d = '0;
                    state_d   = S_DONE;
                end else begin
                    rnd_cnt_d = rnd_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rnd_cnt_q <= '0;
            ks_q      <= '0;
            for (int i = 0; i < 16; i++) begin
                x_q[i]    <= '0;
                init_q[i] <= '0;
            end
`ifdef CHACHA_XOR_EN
            data_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rnd_cnt_q <= rnd_cnt_d;
            ks_q      <= ks_d;
            x_q       <= x_d;
            init_q    <= init_d;
`ifdef CHACHA_XOR_EN
            data_q    <= data_d;
`endif
        end
    end

    assign ks_out    = ks_q;
    assign dbg_state = state_q;

endmodule
